// File: rtl/mem_bank_if.sv
// mem_bank_if: write-back and read-port bundle for mem_bank.
//   master: drives dataWB_enable/dataWB_data and rd_en/rd_addr; receives rd_data, rd_valid, mem_ready.
//   slave : the memory side of the same signals.
// dataWB_data packing: [WB_W-1 -: ADDR_W] address, [DATA_W-1:0] data, PAD_W unused bits between.
interface mem_bank_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned PAD_W  = 3,
    parameter int unsigned NUM_RD = 2
);
    localparam int unsigned WB_W = ADDR_W + PAD_W + DATA_W;

    logic                       dataWB_enable;
    logic [WB_W-1:0]            dataWB_data;
    logic [NUM_RD-1:0]          rd_en;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_valid;
    logic                       mem_ready;

    modport master (
        output dataWB_enable, dataWB_data, rd_en, rd_addr,
        input  rd_data, rd_valid, mem_ready
    );

    modport slave (
        input  dataWB_enable, dataWB_data, rd_en, rd_addr,
        output rd_data, rd_valid, mem_ready
    );
endinterface

// File: rtl/mem_bank.sv
// mem_bank: DEPTH = 2^ADDR_W words of DATA_W bits with one packed write-back port and
// NUM_RD independent registered read ports. After every reset a clear sweep zeroes one
// word per cycle; mem_ready rises once the sweep is done and accesses are accepted.
// Ports:
//   clock   - single clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - mem_bank_if.slave (write-back bus, read ports, mem_ready)
// Build option:
//   MEM_BYPASS_EN - when defined, a read hitting the address being written in the same
//                   cycle returns the new write data; otherwise it returns the old contents.
module mem_bank #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned PAD_W  = 3,
    parameter int unsigned NUM_RD = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    mem_bank_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned WB_W  = ADDR_W + PAD_W + DATA_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                     state;
    logic [ADDR_W-1:0]          clr_cnt;
    logic                       ready_q;
    logic [NUM_RD-1:0]          valid_q;
    logic [NUM_RD*DATA_W-1:0]   data_q;

    logic [DATA_W-1:0]          mem [DEPTH];

    logic [ADDR_W-1:0]          wb_addr_c;
    logic [DATA_W-1:0]          wb_word_c;
    logic                       wr_en_c;
    logic [DATA_W-1:0]          rd_word_c [NUM_RD];
    logic                       unused_pad_c;

    // Write-back bus field decode; pad bits carry nothing.
    assign wb_addr_c    = bus.dataWB_data[WB_W-1 -: ADDR_W];
    assign wb_word_c    = bus.dataWB_data[DATA_W-1:0];
    assign unused_pad_c = ^bus.dataWB_data[DATA_W +: PAD_W];
    assign wr_en_c      = (state == RUN) && bus.dataWB_enable;

    // Array storage: the clear sweep owns the write port until RUN.
    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en_c) begin
            mem[wb_addr_c] <= wb_word_c;
        end
    end

    // Per-port read word, with optional same-cycle write forwarding.
    always_comb begin
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_word_c[p] = mem[bus.rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef MEM_BYPASS_EN
            if (wr_en_c && (bus.rd_addr[p*ADDR_W +: ADDR_W] == wb_addr_c)) begin
                rd_word_c[p] = wb_word_c;
            end
`endif
        end
    end

    // Sweep/run FSM with registered read outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready_q <= 1'b0;
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    valid_q <= '0;
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    for (int unsigned p = 0; p < NUM_RD; p++) begin
                        valid_q[p] <= bus.rd_en[p];
                        if (bus.rd_en[p]) begin
                            data_q[p*DATA_W +: DATA_W] <= rd_word_c[p];
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.rd_valid  = valid_q;
    assign bus.rd_data   = data_q;
endmodule

// File: doc/mem_bank.md
# mem_bank

Parametrised data-memory bank for the write-back stage: DEPTH = 2^ADDR_W words of DATA_W bits, one packed write-back port, and NUM_RD independent registered read ports. After every reset it runs a hardware clear sweep, zeroing one word per cycle, and signals when it is usable. It sits where the fixed 8x16 write-back memory sits today; with default parameters the write-back bus keeps the same 22-bit packing.

## Interface
- DATA_W, 16, word width in bits
- ADDR_W, 3, address width; DEPTH = 2^ADDR_W
- PAD_W, 3, unused bits between the address and data fields of dataWB_data
- NUM_RD, 2, number of read ports (1..4)
- WB_W, ADDR_W+PAD_W+DATA_W, derived localparam; width of the write-back bus
- clock  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- dataWB_enable  in  1  write request for the current cycle
- dataWB_data  in  WB_W  [WB_W-1 -: ADDR_W] = address; [DATA_W-1:0] = data; pad bits ignored
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port p uses bits [p*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  per-port read-data valid
- mem_ready  out  1  high when the clear sweep is done and accesses are accepted

## Operation
- The FSM has two states: CLEAR and RUN.
- While reset_n=0: state=CLEAR, clr_cnt=0, mem_ready=0, rd_valid=0, rd_data=0. Array contents are not reset directly.
- CLEAR state:
  - Each cycle, write 0 to mem[clr_cnt], then increment clr_cnt.
  - At clr_cnt==DEPTH-1, write that word and go to RUN on the same edge.
  - The sweep takes exactly DEPTH cycles. clr_cnt is ADDR_W bits wide; it wraps to 0 on entering RUN.
  - dataWB_enable is ignored and the write is dropped.
  - rd_en is ignored, so rd_valid stays 0.
- RUN state: mem_ready=1. The block stays in RUN until reset.
- Write: if dataWB_enable=1, mem[addr field] <= data field. Pad bits have no effect.
- Read, per port p independently: if rd_en[p]=1, rd_data[p] <= mem[rd_addr[p]] and rd_valid[p] <= 1. Otherwise rd_valid[p] <= 0 and rd_data[p] holds its last value.
- Any number of ports may read the same address in the same cycle. Each gets identical data.
- Same-cycle read and write to the same address: the result depends on MEM_BYPASS_EN (see Configuration).
- Reset asserted mid-operation: outputs clear immediately, with no clock edge needed. A full sweep reruns after release, so prior contents are lost.

## Timing
- Read latency: 1 cycle. rd_en at edge N gives rd_valid and rd_data visible after edge N+1.
- Write latency: 1 cycle. The data is readable by a rd_en issued in the cycle after the write.
- mem_ready rises DEPTH cycles after the first rising clock edge with reset_n=1, which is 8 cycles at defaults.
- No backpressure exists. A read issued every cycle returns a result every cycle. mem_ready is the only flow-control signal.

## Configuration
- MEM_BYPASS_EN defined:
  - A read and a write to the same address in the same cycle return the new write data.
  - This applies to all matching ports.
- MEM_BYPASS_EN undefined:
  - The same case returns the old contents (read-before-write).
  - The write still completes.

## Test plan
- Reset, then release with idle inputs: mem_ready=0 for 8 cycles, then 1. Reading all 8 addresses returns 0x0000 with rd_valid=1.
- In RUN, write addr 5 with data 0x0028 (dataWB_data=22'h28_0028 at defaults), then read port 0 addr 5 next cycle: rd_data[15:0]=0x0028 one cycle later.
- Write addr 3 with 0x1234, then read addr 3 on both ports in the same cycle: both ports return 0x1234, and rd_valid=2'b11.
- Same cycle, write addr 2 with 0xBEEF and read addr 2 on port 1, where mem[2]=0x000A: the result is 0xBEEF with MEM_BYPASS_EN and 0x000A without. The next read of addr 2 returns 0xBEEF in both builds.
- Write with dataWB_enable=1 during CLEAR (addr 1, 0xFFFF): after mem_ready rises, a read of addr 1 returns 0x0000.
- In RUN, with addr 4 holding 0x0020, assert reset_n=0 while a read is in flight: rd_valid and mem_ready go to 0 without a clock edge. After release and the 8-cycle sweep, addr 4 reads 0x0000.
